// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer handlers (write and read side).
// Gray conversions and the full compare work on 32-bit zero-extended values; callers pass their own width.
package fifo_pkg;

  localparam int FIFO_PTR_WIDTH = 3;
  localparam int FIFO_DEPTH     = 1 << FIFO_PTR_WIDTH;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

  // The writer is exactly one lap ahead when its Gray pointer equals the reader's
  // Gray pointer with the two most significant bits inverted.
  function automatic logic full_match(input logic [31:0] wgray,
                                      input logic [31:0] rgray,
                                      input int          width);
    logic [31:0] mask;
    mask = 32'd3 << (width - 2);
    return wgray == (rgray ^ mask);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/wptr_handler.sv
// Write-side pointer and flag logic of the async FIFO, entirely in the wclk domain.
// full and wcount are pessimistic: they only see reads after the read pointer crosses the synchroniser.
module wptr_handler
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH    = FIFO_PTR_WIDTH,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 w_en,
  input  logic [PTR_WIDTH:0]   g_rptr_sync,
  input  logic                 ovf_clr,
  output logic                 w_accept,
  output logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wcount,
  output logic                 overflow
);

  localparam int W = PTR_WIDTH + 1;

  logic [W-1:0] wbin_next;
  logic [W-1:0] wgray_next;
  logic [W-1:0] rbin_sync;
  logic [W-1:0] cnt_next;
  logic         full_next;
  logic         afull_next;

  assign w_accept = w_en & ~full;

  gray2bin #(.WIDTH(W)) u_rptr_g2b (
    .gray (g_rptr_sync),
    .bin  (rbin_sync)
  );

  // Pointers compare rather than count increments, so a multi-step read jump is still exact.
  always_comb begin
    wbin_next  = b_wptr + {{(W-1){1'b0}}, w_accept};
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    full_next  = full_match(32'(wgray_next), 32'(g_rptr_sync), W);
    cnt_next   = wbin_next - rbin_sync;
    afull_next = 32'(cnt_next) >= 32'(AFULL_THRESH);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      b_wptr <= '0;
      g_wptr <= '0;
    end else begin
      b_wptr <= wbin_next;
      g_wptr <= wgray_next;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      wcount      <= '0;
    end else begin
      full        <= full_next;
      almost_full <= afull_next;
      wcount      <= cnt_next;
    end
  end

  // A rejected write beats a simultaneous clear so that no overflow event is ever lost.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      overflow <= 1'b0;
    end else if (w_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wptr_handler.sv
// Scoreboard bench for wptr_handler: the driver pushes model predictions, a monitor pops and compares.
// The model tracks total writes and reads as plain integers; occupancy is their difference mod 16.
module tb_wptr_handler;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       w_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] g_rptr_sync = 4'd0;
  logic       w_accept;
  logic [3:0] b_wptr;
  logic [3:0] g_wptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wcount;
  logic       overflow;

  typedef struct {
    logic       acc;
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] cnt;
    logic       full;
    logic       af;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   mw = 0;
  int   rd = 0;
  int   mw_d1 = 0;
  int   mw_d2 = 0;
  int   seen_acc = 0;
  logic mfull = 1'b0;
  logic movf = 1'b0;

  always #5 wclk = ~wclk;

  wptr_handler #(.PTR_WIDTH(3), .AFULL_THRESH(6)) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .w_en        (w_en),
    .g_rptr_sync (g_rptr_sync),
    .ovf_clr     (ovf_clr),
    .w_accept    (w_accept),
    .b_wptr      (b_wptr),
    .g_wptr      (g_wptr),
    .full        (full),
    .almost_full (almost_full),
    .wcount      (wcount),
    .overflow    (overflow)
  );

  function automatic logic [3:0] to_gray(input int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive inputs for the coming edge and predict the state that edge must produce.
  task automatic drive(input logic w, input int r, input logic clr);
    exp_t e;
    int   cnt;
    w_en        = w;
    g_rptr_sync = to_gray(r);
    ovf_clr     = clr;
    e.acc = w & ~mfull;
    e.ovf = (w && mfull) ? 1'b1 : (clr ? 1'b0 : movf);
    if (e.acc) mw++;
    cnt    = (mw - r) & 15;
    e.b    = 4'(mw);
    e.g    = to_gray(mw);
    e.cnt  = 4'(cnt);
    e.full = (cnt == 8);
    e.af   = (cnt >= 6);
    mfull  = e.full;
    movf   = e.ovf;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic w, input int r, input logic clr);
    @(posedge wclk);
    #2;
    drive(w, r, clr);
  endtask

  // Reset lands between edges; outputs must clear before any further clock edge.
  task automatic do_reset(input logic w);
    @(posedge wclk);
    #3;
    wrst = 1'b1;
    #1;
    check_output("rst_b_wptr", b_wptr, 0);
    check_output("rst_g_wptr", g_wptr, 0);
    check_output("rst_full", full, 0);
    check_output("rst_afull", almost_full, 0);
    check_output("rst_wcount", wcount, 0);
    check_output("rst_overflow", overflow, 0);
    mw = 0;
    rd = 0;
    mw_d1 = 0;
    mw_d2 = 0;
    mfull = 1'b0;
    movf = 1'b0;
    seen_acc = 0;
    wrst = 1'b0;
    drive(w, 0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    logic acc_seen;
    forever begin
      @(negedge wclk);
      if (exp_q.size() > 0) begin
        acc_seen = w_accept;
        check_output("accept_while_full", {31'd0, w_accept & full}, 0);
        @(posedge wclk);
        #1;
        e = exp_q.pop_front();
        if (acc_seen) seen_acc++;
        check_output("w_accept", acc_seen, e.acc);
        check_output("b_wptr", b_wptr, e.b);
        check_output("g_wptr", g_wptr, e.g);
        check_output("wcount", wcount, e.cnt);
        check_output("full", full, e.full);
        check_output("almost_full", almost_full, e.af);
        check_output("overflow", overflow, e.ovf);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int rfix;
    logic w;
    logic clr;
    do_reset(1'b0);

    // Reset in the middle of a write burst, w_en held high through release.
    repeat (4) apply_stimulus(1'b1, 0, 1'b0);
    do_reset(1'b1);
    apply_stimulus(1'b1, 0, 1'b0);
    check_output("first_after_reset", b_wptr, 4'd1);

    // Fill the remaining slots with the reader parked at 0.
    repeat (6) apply_stimulus(1'b1, 0, 1'b0);

    // Overflow handling from full.
    apply_stimulus(1'b1, 0, 1'b0);
    check_output("fill_b_wptr", b_wptr, 4'b1000);
    check_output("fill_g_wptr", g_wptr, 4'b1100);
    check_output("fill_full", full, 1'b1);
    apply_stimulus(1'b0, 0, 1'b0);
    check_output("ovf_set", overflow, 1'b1);
    check_output("ovf_hold_ptr", b_wptr, 4'b1000);
    apply_stimulus(1'b0, 0, 1'b1);
    apply_stimulus(1'b1, 0, 1'b1);
    check_output("ovf_cleared", overflow, 1'b0);
    apply_stimulus(1'b0, 0, 1'b0);
    check_output("ovf_set_wins", overflow, 1'b1);

    // Drain: reader jumps to binary 3.
    apply_stimulus(1'b0, 3, 1'b0);
    apply_stimulus(1'b1, 3, 1'b0);
    check_output("drain_full", full, 1'b0);
    check_output("drain_wcount", wcount, 4'd5);
    apply_stimulus(1'b0, 3, 1'b1);
    check_output("drain_write", b_wptr, 4'd9);

    // Wrap through 15->0 with the reader trailing, then fill one lap ahead of reader 9.
    repeat (16) apply_stimulus(1'b1, mw - 1, 1'b0);
    rfix = mw;
    repeat (8) apply_stimulus(1'b1, rfix, 1'b0);
    apply_stimulus(1'b0, rfix, 1'b0);
    check_output("wrap_full", full, 1'b1);
    check_output("wrap_b_wptr", b_wptr, 4'd1);

    // Random traffic with a reader that lags the writer by the synchroniser delay.
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      w   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      if (rd < mw_d2 && $urandom_range(0, 1) == 1) begin
        rd += (rd + 1 < mw_d2 && $urandom_range(0, 7) == 0) ? 2 : 1;
      end
      apply_stimulus(w, rd, clr);
      mw_d2 = mw_d1;
      mw_d1 = mw;
    end

    repeat (2) @(posedge wclk);
    #3;
    check_output("queue_drained", exp_q.size(), 0);
    check_output("accept_count", seen_acc, mw);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
